fpu_cmd_queue: RTL and testbench
================================

# fpu_cmd_queue

Buffered issue stage directly upstream of the combinational FPU (add/mul with rounding). It accepts FPU commands over a valid/ready handshake and holds them in a small in-order FIFO. It presents the head command to the FPU and captures the FPU's combinational result into a registered output slot, which is tagged and drained over a second valid/ready handshake. This decouples the producer (decode/issue) from the consumer (register writeback) and cuts the timing path through the FPU.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TAG_W, 5, width of the opaque tag carried with each command (e.g. destination register)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of FIFO and output slot
- in_valid  in  1  command offered
- in_ready  out  1  queue can accept a command this cycle
- in_op1 / in_op2 / in_op3  in  32 each  operands
- in_funct  in  5  FPU function code (1 = add, 2 = mul)
- in_round_mode  in  2  rounding mode (0 = nearest, 1 = toward zero, 2 = down, 3 = up)
- in_tag  in  TAG_W  tag returned with the result
- fpu_op1 / fpu_op2 / fpu_op3  out  32 each  head-entry operands to the FPU
- fpu_funct  out  5  head-entry function code
- fpu_round_mode  out  2  head-entry rounding mode
- fpu_result  in  32  combinational FPU result for the fpu_* inputs
- out_valid  out  1  result slot occupied
- out_ready  in  1  consumer accepts the result
- out_result  out  32  registered result
- out_tag  out  TAG_W  tag of out_result
- out_funct  out  5  funct of out_result
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output slot

## Operation
- Push: in_valid & in_ready writes the command at wr_ptr, then wr_ptr++.
- in_ready = (count != DEPTH) & ~flush. It does not depend on a same-cycle pop, so a full queue stays non-ready for one cycle even while it is draining.
- fpu_* outputs are driven from the head entry. They hold the last head contents when the queue is empty; their value is don't-care when count == 0.
- Issue/pop: when count != 0 and (~out_valid or out_ready):
  - fpu_result, the head tag and the head funct load into the output slot;
  - out_valid is set to 1;
  - rd_ptr++.
- Drain: out_valid & out_ready with no issue in the same cycle clears out_valid.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately to tell full from empty.
- flush has priority over every other event. It zeroes count, rd_ptr and wr_ptr and clears out_valid. The in-flight push and issue in that cycle are discarded.
- No reordering, no dropping and no funct checking: an unknown funct is issued as-is.
- Reset (async assert, any cycle, including mid-drain): count = 0, rd_ptr = wr_ptr = 0, out_valid = 0, out_result = 0, out_tag = 0, out_funct = 0. in_ready is 1 after reset deassertion. FIFO storage is not reset.

## Timing
- Latency: a command accepted at edge N appears with out_valid = 1 after edge N+1, provided the output slot is free or draining.
- Throughput: one command per cycle sustained, as long as out_ready is held at 1 and the queue is not full.
- out_* outputs are registered. in_ready, count and fpu_* depend only on registered state and flush.
- out_result, out_tag and out_funct stay stable while out_valid & ~out_ready.

## Structure
- Shared package fpu_pkg holds:
  - FPU_ADD = 1, FPU_MUL = 2;
  - ROUND_TONEAREST, ROUND_TOWARDZERO, ROUND_DOWNWARD, ROUND_UPWARD = 0..3;
  - the packed command struct {op1, op2, op3, funct, round_mode} (the tag stays outside it, because TAG_W is a parameter).
- One sub-module, fpu_cmd_fifo: a generic synchronous FIFO (DEPTH, WIDTH), with push/pop/flush, count, full and empty, and head data output.
- The output slot and the issue logic live in fpu_cmd_queue.

## Test plan
- Single add: push op1 = 0x3F800000, op2 = 0x40000000, funct = 1, tag = 3 at edge 0, with out_ready = 1, using a reference FPU model. Required: out_valid after edge 1, out_result = 0x40400000, out_tag = 3, out_funct = 1.
- Fill/backpressure with DEPTH = 4, out_ready = 0: push 6 commands. Required: 1 moves into the slot, 4 are queued, in_ready = 0 with count = 4. Then raise out_ready. Required: results drain in push order with tags 0..4, and in_ready returns one cycle after the first pop.
- Pointer wrap: stream 20 muls, e.g. 0x40000000 × 0x40400000 → 0x40C00000, with random out_ready. Required: no loss or duplication, and tags stay in sequence.
- Stall hold: with out_valid = 1 and out_ready = 0 for 5 cycles while the head changes. Required: out_result and out_tag stay unchanged.
- Flush while count = 3 and out_valid = 1, with a push in the same cycle. Required next cycle: count = 0, out_valid = 0, and the pushed command is not issued.
- Async RST asserted mid-stream, between clock edges. Required: all outputs reach their reset values immediately, and a push after deassert comes out with correct results and tags.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: function codes, rounding modes
// and the command bundle carried through the issue queue.
package fpu_pkg;

    localparam logic [4:0] FPU_ADD = 5'd1;
    localparam logic [4:0] FPU_MUL = 5'd2;

    localparam logic [1:0] ROUND_TONEAREST  = 2'd0;
    localparam logic [1:0] ROUND_TOWARDZERO = 2'd1;
    localparam logic [1:0] ROUND_DOWNWARD   = 2'd2;
    localparam logic [1:0] ROUND_UPWARD     = 2'd3;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
        logic [4:0]  funct;
        logic [1:0]  round_mode;
    } fpu_cmd_t;

    localparam int CMD_W = $bits(fpu_cmd_t);

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Generic in-order synchronous FIFO with flush.
// Storage is not reset; only pointers and occupancy are.
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push & ~do_pop) count_d = count_q + CNT_ONE;
            if (~do_push & do_pop) count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_cmd_queue.sv
// Buffered issue stage in front of the combinational FPU:
// command FIFO, head issue, registered tagged result slot.
module fpu_cmd_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_op1,
    input  logic [31:0]            in_op2,
    input  logic [31:0]            in_op3,
    input  logic [4:0]             in_funct,
    input  logic [1:0]             in_round_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [31:0]            fpu_op1,
    output logic [31:0]            fpu_op2,
    output logic [31:0]            fpu_op3,
    output logic [4:0]             fpu_funct,
    output logic [1:0]             fpu_round_mode,
    input  logic [31:0]            fpu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [4:0]             out_funct,
    output logic [$clog2(DEPTH):0] count
);

    localparam int EW = CMD_W + TAG_W;

    fpu_cmd_t         in_cmd;
    fpu_cmd_t         head_cmd;
    logic [TAG_W-1:0] head_tag;
    logic [EW-1:0]    head_w;
    logic             full, empty;
    logic             push, issue;

    logic             valid_q, valid_d;
    logic [31:0]      result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [4:0]       funct_q, funct_d;

    assign in_cmd.op1        = in_op1;
    assign in_cmd.op2        = in_op2;
    assign in_cmd.op3        = in_op3;
    assign in_cmd.funct      = in_funct;
    assign in_cmd.round_mode = in_round_mode;

    // Ready ignores a same-cycle pop to keep it off the
    // consumer path: a full queue waits one extra cycle.
    assign in_ready = ~full & ~flush;
    assign push     = in_valid & in_ready;
    assign issue    = ~empty & (~valid_q | out_ready) & ~flush;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i ({in_cmd, in_tag}),
        .rdata_o (head_w),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign {head_cmd, head_tag} = head_w;

    assign fpu_op1        = head_cmd.op1;
    assign fpu_op2        = head_cmd.op2;
    assign fpu_op3        = head_cmd.op3;
    assign fpu_funct      = head_cmd.funct;
    assign fpu_round_mode = head_cmd.round_mode;

    // Result slot: issue refills it, drain empties it.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        tag_d    = tag_q;
        funct_d  = funct_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (issue) begin
            valid_d  = 1'b1;
            result_d = fpu_result;
            tag_d    = head_tag;
            funct_d  = head_cmd.funct;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result slot registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            funct_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            funct_q  <= funct_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_tag    = tag_q;
    assign out_funct  = funct_q;

endmodule

// File: tb/tb_fpu_cmd_queue.sv
// Bench for fpu_cmd_queue: reference FPU, queue-level model
// with per-cycle compare, plus directed literal checks.
module tb_fpu_cmd_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_op1 = '0, in_op2 = '0, in_op3 = '0;
    logic [4:0]       in_funct = '0;
    logic [1:0]       in_round_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      fpu_op1, fpu_op2, fpu_op3;
    logic [4:0]       fpu_funct;
    logic [1:0]       fpu_round_mode;
    logic [31:0]      fpu_result;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       out_funct;
    logic [2:0]       count;

    int tests = 0;
    int errs  = 0;

    fpu_cmd_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
        .in_funct(in_funct), .in_round_mode(in_round_mode),
        .in_tag(in_tag),
        .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_op3(fpu_op3),
        .fpu_funct(fpu_funct), .fpu_round_mode(fpu_round_mode),
        .fpu_result(fpu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_funct(out_funct), .count(count)
    );

    always #5 CLK = ~CLK;

    // Single <-> double for normal values (exact test operands)
    function automatic logic [63:0] s2d(input logic [31:0] x);
        if (x[30:0] == '0) return {x[31], 63'b0};
        return {x[31], {3'b0, x[30:23]} + 11'd896, x[22:0], 29'b0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == '0) return {d[63], 31'b0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [4:0] f);
        real ra, rb;
        ra = $bitstoreal(s2d(a));
        rb = $bitstoreal(s2d(b));
        if (f == FPU_ADD) return d2s($realtobits(ra + rb));
        if (f == FPU_MUL) return d2s($realtobits(ra * rb));
        return a ^ b;
    endfunction

    assign fpu_result = fpu_ref(fpu_op1, fpu_op2, fpu_funct);

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        tests++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    typedef struct {
        logic [31:0]      op1, op2, op3;
        logic [4:0]       f;
        logic [1:0]       rm;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t             mq[$];
    bit               sv;
    logic [31:0]      sres;
    logic [TAG_W-1:0] stag;
    logic [4:0]       sf;
    logic [TAG_W-1:0] dlog[$];

    // Queue-level model: advance one clock from stable inputs.
    always @(posedge CLK or posedge RST) begin
        cmd_t h, c;
        bit   p, iss;
        if (RST) begin
            mq.delete();
            sv = 0;
        end else if (flush) begin
            mq.delete();
            sv = 0;
        end else begin
            p   = in_valid && (mq.size() != DEPTH);
            iss = (mq.size() != 0) && (!sv || out_ready);
            c.op1 = in_op1; c.op2 = in_op2; c.op3 = in_op3;
            c.f = in_funct; c.rm = in_round_mode; c.tag = in_tag;
            if (iss) begin
                h    = mq.pop_front();
                sres = fpu_ref(h.op1, h.op2, h.f);
                stag = h.tag;
                sf   = h.f;
                sv   = 1;
            end else if (sv && out_ready) begin
                sv = 0;
            end
            if (p) mq.push_back(c);
        end
    end

    // Per-cycle compare against the model, mid-cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("in_ready", in_ready, (mq.size() != DEPTH) && !flush);
            chk("count", count, mq.size());
            chk("out_valid", out_valid, sv);
            if (sv) begin
                chk("out_result", out_result, sres);
                chk("out_tag", out_tag, stag);
                chk("out_funct", out_funct, sf);
            end
            if (mq.size() != 0) begin
                chk("fpu_op1", fpu_op1, mq[0].op1);
                chk("fpu_op2", fpu_op2, mq[0].op2);
                chk("fpu_op3", fpu_op3, mq[0].op3);
                chk("fpu_funct", fpu_funct, mq[0].f);
                chk("fpu_rm", fpu_round_mode, mq[0].rm);
            end
            if (out_valid && out_ready) dlog.push_back(out_tag);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] f,
                         input logic [TAG_W-1:0] t);
        in_valid      = 1'b1;
        in_op1        = a;
        in_op2        = b;
        in_op3        = a ^ b;
        in_funct      = f;
        in_round_mode = t[1:0];
        in_tag        = t;
    endtask

    logic [31:0] tbl [4] = '{32'h3F800000, 32'h40000000,
                             32'h3FC00000, 32'h3F000000};

    initial begin
        int  k, cyc;
        bit  acc;

        // pin the reference FPU itself
        chk("ref_add", fpu_ref(32'h3F800000, 32'h40000000, FPU_ADD),
            32'h40400000);
        chk("ref_mul", fpu_ref(32'h40000000, 32'h40400000, FPU_MUL),
            32'h40C00000);

        // reset state
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_result", out_result, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_funct", out_funct, 0);
        RST = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);
        step();

        // single add
        out_ready = 1'b1;
        drive(32'h3F800000, 32'h40000000, FPU_ADD, 5'd3);
        step();
        in_valid = 1'b0;
        chk("add_valid0", out_valid, 0);
        chk("add_count", count, 1);
        step();
        chk("add_valid1", out_valid, 1);
        chk("add_result", out_result, 32'h40400000);
        chk("add_tag", out_tag, 3);
        chk("add_funct", out_funct, 1);
        step();
        chk("add_drained", out_valid, 0);

        // fill with backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(32'h3F800000, tbl[i % 4], FPU_ADD, 5'(i));
            step();
        end
        in_valid = 1'b0;
        chk("fill_count", count, 4);
        chk("fill_ready", in_ready, 0);
        chk("fill_slot_tag", out_tag, 0);
        dlog.delete();
        out_ready = 1'b1;
        step();
        chk("fill_ready_back", in_ready, 1);
        repeat (6) step();
        chk("fill_drain_n", dlog.size(), 5);
        for (int i = 0; i < 5 && i < dlog.size(); i++)
            chk("fill_order", dlog[i], i);
        chk("fill_empty", count, 0);

        // pointer wrap with random backpressure
        dlog.delete();
        k = 0;
        cyc = 0;
        while (k < 20 && cyc < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            drive(tbl[k % 4], 32'h40400000, FPU_MUL, 5'(k));
            acc = in_ready;
            step();
            if (acc) k++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        chk("wrap_pushed", k, 20);
        chk("wrap_drain_n", dlog.size(), 20);
        for (int i = 0; i < 20 && i < dlog.size(); i++)
            chk("wrap_order", dlog[i], i);

        // stall hold while head changes
        out_ready = 1'b0;
        drive(32'h40400000, 32'h40400000, FPU_ADD, 5'd7);
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i < 3)
                drive(tbl[i], 32'h40000000, FPU_MUL, 5'(10 + i));
            else
                in_valid = 1'b0;
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_result", out_result, 32'h40C00000);
            chk("stall_tag", out_tag, 7);
        end
        in_valid = 1'b0;
        chk("stall_count", count, 3);

        // flush with a same-cycle push
        flush = 1'b1;
        drive(32'h3F800000, 32'h3F800000, FPU_ADD, 5'd9);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        dlog.delete();
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_no_issue", dlog.size(), 0);
        chk("flush_valid2", out_valid, 0);

        // async reset mid-stream
        drive(32'h3F800000, 32'h3F800000, FPU_ADD, 5'd1);
        step();
        drive(32'h40000000, 32'h3F800000, FPU_ADD, 5'd2);
        step();
        in_valid = 1'b0;
        #3;
        RST = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_result", out_result, 0);
        chk("arst_tag", out_tag, 0);
        chk("arst_funct", out_funct, 0);
        step();
        #2;
        RST = 1'b0;
        step();
        drive(32'h3FC00000, 32'h40000000, FPU_MUL, 5'd21);
        step();
        in_valid = 1'b0;
        step();
        chk("post_valid", out_valid, 1);
        chk("post_result", out_result, 32'h40400000);
        chk("post_tag", out_tag, 21);
        chk("post_funct", out_funct, 2);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
